cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
//  Controller FSM for a direct-mapped, write-through cache between CPU and main memory.
//  Sequences read hits, multi-word line fills and write-through stores.
//  Generalises the single-word controller: line length and memory latency are parameters.
//  Word and latency counters are internal, so no external counter handshake is needed.
// PARAMETERS
//  WORDS_PER_LINE  4   words per cache line; power of 2, >=1
//  MEM_LAT         2   memory access latency in cycles, >=1
//  STAT_W          16  width of statistics counters (CACHE_STATS_EN only)
//  IDX_W           $clog2(WORDS_PER_LINE) (min 1), derived, not overridable
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high
//  strobe     in   1      CPU request; sampled only in IDLE
//  rw         in   1      1=read, 0=write; sampled with strobe
//  match      in   1      tag compare result, valid in LOOKUP
//  valid      in   1      line valid bit, valid in LOOKUP
//  rdy        out  1      request complete, 1-cycle pulse
//  cache_we   out  1      write enable to cache data array
//  wsel       out  1      cache write data: 0=memory, 1=CPU
//  valid_set  out  1      set valid bit of indexed line
//  word_idx   out  IDX_W  word offset for the fill in progress
//  mstrobe    out  1      memory request, 1-cycle pulse
//  mrw        out  1      memory direction: 1=read, 0=write
//  busy       out  1      high in every state except IDLE
//  hit_cnt    out  STAT_W hits counted (CACHE_STATS_EN only)
//  miss_cnt   out  STAT_W misses counted (CACHE_STATS_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; counters 0. Reset mid-transaction aborts it, no rdy.
//  - All outputs are Moore, decoded from registered state (cache_we also uses hit_q).
//  - IDLE:      strobe=1 -> latch rw_q; go to LOOKUP.
//  - LOOKUP:    hit=match&valid; latch hit_q.
//      read hit -> DONE; read miss -> FILL_REQ, word_idx=0; write -> WR_MEM.
//  - FILL_REQ:  mstrobe=1, mrw=1; lat_ctr=MEM_LAT-1; go to FILL_WAIT.
//  - FILL_WAIT: lat_ctr--; at 0 go to FILL_WR. Lasts MEM_LAT cycles.
//  - FILL_WR:   cache_we=1, wsel=0.
//      word_idx==WORDS_PER_LINE-1 -> valid_set=1, go to DONE; else word_idx++, go to FILL_REQ.
//  - WR_MEM:    mstrobe=1, mrw=0; cache_we=hit_q, wsel=1 (write miss: no allocate); lat_ctr=MEM_LAT-1.
//  - WR_WAIT:   as FILL_WAIT; at 0 go to DONE.
//  - DONE:      rdy=1 for exactly one cycle; go to IDLE. strobe in DONE is ignored.
//  - Latency (strobe sampled = cycle 0): rdy high in cycle
//      read hit 2; read miss 2+WORDS_PER_LINE*(MEM_LAT+2); write 3+MEM_LAT.
//  - strobe/rw changes outside IDLE are ignored; match/valid are don't-care outside LOOKUP.
//  - word_idx holds its last value after a fill and resets to 0 on entry to FILL_REQ from LOOKUP.
//  - Illegal state encoding -> IDLE on next clock.
// CONFIGURATION
//  CACHE_STATS_EN defined: in LOOKUP, hit_cnt++ on read hit or write hit;
//    miss_cnt++ otherwise. Both saturate at all-ones; cleared by reset.
//  CACHE_STATS_EN undefined: hit_cnt/miss_cnt ports and their logic are absent.
// STRUCTURE
//  cache_ctrl_pkg: state_t enum (IDLE, LOOKUP, FILL_REQ, FILL_WAIT, FILL_WR, WR_MEM,
//    WR_WAIT, DONE); RD=1'b1 / WR=1'b0 constants.
//  Sub-module cache_lat_ctr: loadable down-counter with zero flag, used for lat_ctr.
// TESTING
//  1 Read hit (match=1,valid=1): rdy at cycle 2; mstrobe and cache_we never asserted.
//  2 Read miss, WORDS=4, LAT=2: 4 mstrobe pulses with mrw=1; cache_we with word_idx 0..3;
//      valid_set on the last fill write; rdy at cycle 18.
//  3 Write hit, LAT=2: one mstrobe with mrw=0; cache_we=1, wsel=1; rdy at cycle 5.
//  4 Write miss: mstrobe with mrw=0; cache_we stays 0; rdy at cycle 5.
//  5 Reset during FILL_WAIT of word 2: next cycle all outputs 0, state IDLE, no rdy;
//      a following read hit completes normally.
//  6 CACHE_STATS_EN, STAT_W=2: 5 hits -> hit_cnt saturates at 3; 1 miss -> miss_cnt=1.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL_WAIT,
    FILL_WR,
    WR_MEM,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, tag-compare, cache-array and memory handshake signals of the cache controller.
interface cache_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             strobe;
  logic             rw;
  logic             match;
  logic             valid;
  logic             rdy;
  logic             cache_we;
  logic             wsel;
  logic             valid_set;
  logic [IDX_W-1:0] word_idx;
  logic             mstrobe;
  logic             mrw;
  logic             busy;

  modport master (
    output strobe, rw, match, valid,
    input  rdy, cache_we, wsel, valid_set, word_idx, mstrobe, mrw, busy
  );

  modport slave (
    input  strobe, rw, match, valid,
    output rdy, cache_we, wsel, valid_set, word_idx, mstrobe, mrw, busy
  );
endinterface

// File: rtl/cache_lat_ctr.sv
// Loadable down-counter with zero flag; paces the memory latency wait states.
module cache_lat_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-through cache controller: read hits, multi-word line fills, write-through.
// Optional saturating hit/miss counters when CACHE_STATS_EN is defined.
//   state     | meaning
//   IDLE      | wait for CPU strobe       LOOKUP    | evaluate tag hit
//   FILL_REQ  | request one line word     FILL_WAIT | memory latency for fill word
//   FILL_WR   | write fill word to cache  WR_MEM    | write-through request (+cache on hit)
//   WR_WAIT   | memory latency for store  DONE      | one-cycle rdy pulse
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LAT        = 2
`ifdef CACHE_STATS_EN
  ,
  parameter int STAT_W         = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt,
`endif
  cache_ctrl_if.slave       bus
);

  localparam int IDX_W = idx_w(WORDS_PER_LINE);
  localparam int LAT_W = idx_w(MEM_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  state_t           state;
  logic             rw_q;
  logic             hit_q;
  logic             rdy_q;
  logic             wsel_q;
  logic             valid_set_q;
  logic             mstrobe_q;
  logic             mrw_q;
  logic             busy_q;
  logic [IDX_W-1:0] word_idx_q;
  logic             hit;
  logic             lat_zero;
  logic             lat_load;
  logic             lat_dec;

  assign hit      = bus.match & bus.valid;
  assign lat_load = (state == FILL_REQ) || (state == WR_MEM);
  assign lat_dec  = ((state == FILL_WAIT) || (state == WR_WAIT)) && !lat_zero;

  cache_lat_ctr #(.W(LAT_W)) u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .dec      (lat_dec),
    .load_val (LAT_LOAD),
    .zero     (lat_zero)
  );

  // Outputs are registered alongside the state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rw_q        <= 1'b0;
      hit_q       <= 1'b0;
      rdy_q       <= 1'b0;
      wsel_q      <= 1'b0;
      valid_set_q <= 1'b0;
      mstrobe_q   <= 1'b0;
      mrw_q       <= 1'b0;
      busy_q      <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      rdy_q       <= 1'b0;
      wsel_q      <= 1'b0;
      valid_set_q <= 1'b0;
      mstrobe_q   <= 1'b0;
      mrw_q       <= 1'b0;
      busy_q      <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.strobe) begin
            rw_q  <= bus.rw;
            state <= LOOKUP;
          end else begin
            busy_q <= 1'b0;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          if (rw_q == RD && hit) begin
            rdy_q <= 1'b1;
            state <= DONE;
          end else if (rw_q == RD) begin
            word_idx_q <= '0;
            mstrobe_q  <= 1'b1;
            mrw_q      <= RD;
            state      <= FILL_REQ;
          end else begin
            mstrobe_q <= 1'b1;
            mrw_q     <= WR;
            wsel_q    <= 1'b1;
            state     <= WR_MEM;
          end
        end
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: begin
          if (lat_zero) begin
            valid_set_q <= (word_idx_q == LAST_IDX);
            state       <= FILL_WR;
          end
        end
        FILL_WR: begin
          if (word_idx_q == LAST_IDX) begin
            rdy_q <= 1'b1;
            state <= DONE;
          end else begin
            word_idx_q <= word_idx_q + IDX_W'(1);
            mstrobe_q  <= 1'b1;
            mrw_q      <= RD;
            state      <= FILL_REQ;
          end
        end
        WR_MEM: state <= WR_WAIT;
        WR_WAIT: begin
          if (lat_zero) begin
            rdy_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.cache_we  = (state == FILL_WR) || ((state == WR_MEM) && hit_q);
  assign bus.wsel      = wsel_q;
  assign bus.valid_set = valid_set_q;
  assign bus.word_idx  = word_idx_q;
  assign bus.mstrobe   = mstrobe_q;
  assign bus.mrw       = mrw_q;
  assign bus.busy      = busy_q;

`ifdef CACHE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != STAT_MAX) hit_cnt <= hit_cnt + STAT_W'(1);
      end else if (miss_cnt != STAT_MAX) begin
        miss_cnt <= miss_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm (WORDS_PER_LINE=4, MEM_LAT=2).
module tb_cache_ctrl_fsm;
  import cache_ctrl_pkg::*;

  localparam int WORDS = 4;
  localparam int LAT   = 2;
  localparam int IW    = idx_w(WORDS);

  logic clk = 1'b0;
  logic reset;

  cache_ctrl_if #(.IDX_W(IW)) bus ();

`ifdef CACHE_STATS_EN
  localparam int SW = 2;
  logic [SW-1:0] hit_cnt;
  logic [SW-1:0] miss_cnt;
  cache_ctrl_fsm #(.WORDS_PER_LINE(WORDS), .MEM_LAT(LAT), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .bus(bus)
  );
`else
  cache_ctrl_fsm #(.WORDS_PER_LINE(WORDS), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  int rdy_cyc, rdy_hi, n_ms, n_mrd, n_we, n_we_cpu, n_vs, vs_cyc, vs_idx;
  int busy_bad, ms_cyc, we_cyc, busy_end;
  logic [7:0] idx_seq;

  // Cycle 0 is the cycle in which strobe is sampled; cycle c is observed mid-cycle.
  task automatic run_txn(input logic rw, input logic m, input logic v, input int stop_at);
    rdy_cyc = -1; rdy_hi = 0; n_ms = 0; n_mrd = 0; n_we = 0; n_we_cpu = 0;
    n_vs = 0; vs_cyc = -1; vs_idx = -1; busy_bad = 0; ms_cyc = -1; we_cyc = -1;
    busy_end = -1; idx_seq = '0;
    @(negedge clk);
    bus.strobe = 1'b1; bus.rw = rw; bus.match = m; bus.valid = v;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy_cyc < 0 && !bus.busy) busy_bad++;
      if (bus.rdy) begin
        rdy_hi++;
        if (rdy_cyc < 0) rdy_cyc = c;
      end
      if (bus.mstrobe) begin
        n_ms++; ms_cyc = c;
        if (bus.mrw) n_mrd++;
      end
      if (bus.cache_we) begin
        n_we++; we_cyc = c;
        idx_seq = {idx_seq[5:0], bus.word_idx};
        if (bus.wsel) n_we_cpu++;
      end
      if (bus.valid_set) begin
        n_vs++; vs_cyc = c; vs_idx = int'(bus.word_idx);
      end
      if (c == stop_at) break;
      if (rdy_cyc >= 0 && c == rdy_cyc + 1) begin
        busy_end = int'(bus.busy);
        break;
      end
      if (rdy_cyc >= 0) begin
        bus.strobe = 1'b0;
      end else if (c >= 2) begin
        bus.strobe = 1'b1; bus.rw = ~rw; bus.match = ~m; bus.valid = ~v;
      end
    end
    bus.strobe = 1'b0; bus.rw = 1'b0; bus.match = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"}, bus.rdy, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mstrobe"}, bus.mstrobe, 0);
    chk({tag, "_mrw"}, bus.mrw, 0);
    chk({tag, "_cache_we"}, bus.cache_we, 0);
    chk({tag, "_wsel"}, bus.wsel, 0);
    chk({tag, "_valid_set"}, bus.valid_set, 0);
    chk({tag, "_word_idx"}, bus.word_idx, 0);
    chk({tag, "_state"}, dut.state, IDLE);
  endtask

  initial begin
    reset = 1'b1;
    bus.strobe = 1'b0; bus.rw = 1'b0; bus.match = 1'b0; bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    reset = 1'b0;

    // read hit
    run_txn(RD, 1'b1, 1'b1, 0);
    chk("rh_rdy_cyc", rdy_cyc, 2);
    chk("rh_rdy_width", rdy_hi, 1);
    chk("rh_mstrobe", n_ms, 0);
    chk("rh_cache_we", n_we, 0);
    chk("rh_busy", busy_bad, 0);
    chk("rh_busy_end", busy_end, 0);

    // read miss: 4 words, each REQ + 2 WAIT + WR
    run_txn(RD, 1'b0, 1'b1, 0);
    chk("rm_rdy_cyc", rdy_cyc, 18);
    chk("rm_rdy_width", rdy_hi, 1);
    chk("rm_mstrobe", n_ms, 4);
    chk("rm_mrw_rd", n_mrd, 4);
    chk("rm_last_ms", ms_cyc, 14);
    chk("rm_cache_we", n_we, 4);
    chk("rm_we_cpu", n_we_cpu, 0);
    chk("rm_idx_seq", idx_seq, 8'h1B);
    chk("rm_last_we", we_cyc, 17);
    chk("rm_valid_set_n", n_vs, 1);
    chk("rm_valid_set_cyc", vs_cyc, 17);
    chk("rm_valid_set_idx", vs_idx, 3);
    chk("rm_busy", busy_bad, 0);
    chk("rm_idx_hold", bus.word_idx, 3);

    // write hit
    run_txn(WR, 1'b1, 1'b1, 0);
    chk("wh_rdy_cyc", rdy_cyc, 5);
    chk("wh_mstrobe", n_ms, 1);
    chk("wh_mrw_rd", n_mrd, 0);
    chk("wh_ms_cyc", ms_cyc, 2);
    chk("wh_cache_we", n_we, 1);
    chk("wh_we_cyc", we_cyc, 2);
    chk("wh_wsel", n_we_cpu, 1);
    chk("wh_valid_set", n_vs, 0);
    chk("wh_idx_hold", bus.word_idx, 3);

    // write miss (tag mismatch), then a valid=0 write miss
    run_txn(WR, 1'b0, 1'b1, 0);
    chk("wm_rdy_cyc", rdy_cyc, 5);
    chk("wm_mstrobe", n_ms, 1);
    chk("wm_mrw_rd", n_mrd, 0);
    chk("wm_cache_we", n_we, 0);
    run_txn(WR, 1'b1, 1'b0, 0);
    chk("wi_rdy_cyc", rdy_cyc, 5);
    chk("wi_cache_we", n_we, 0);

    // reset during FILL_WAIT of word 2 (cycle 11)
    run_txn(RD, 1'b1, 1'b0, 11);
    chk("ra_ms_before", n_ms, 3);
    chk("ra_idx_before", bus.word_idx, 2);
    chk("ra_busy_before", bus.busy, 1);
    chk("ra_no_rdy", rdy_hi, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("ra");
    reset = 1'b0;
    run_txn(RD, 1'b1, 1'b1, 0);
    chk("ra_rh_rdy_cyc", rdy_cyc, 2);
    chk("ra_rh_mstrobe", n_ms, 0);

`ifdef CACHE_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    chk("st_hit_rst", hit_cnt, 0);
    chk("st_miss_rst", miss_cnt, 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) run_txn(RD, 1'b1, 1'b1, 0);
    chk("st_hit_2", hit_cnt, 2);
    for (int i = 0; i < 3; i++) run_txn(RD, 1'b1, 1'b1, 0);
    chk("st_hit_sat", hit_cnt, 3);
    chk("st_miss_0", miss_cnt, 0);
    run_txn(WR, 1'b0, 1'b1, 0);
    chk("st_miss_1", miss_cnt, 1);
    chk("st_hit_keep", hit_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
